npc_mem_arbiter: RTL and testbench
==================================

// Module: npc_mem_arbiter
// PURPOSE
//  Shares one memory port between IFU instruction fetch and LSU load/store.
//  Sits between the core units and icache/memory.
//  One transaction outstanding at a time; each response is returned to the requester that owns it.
//  Fixed priority LSU > IFU, with a starvation guard so fetch always makes progress.
// PARAMETERS
//  ADDR_WIDTH    32  byte address width, shared with ifu/idu/exeu
//  DATA_WIDTH    64  memory data width; wmask width = DATA_WIDTH/8
//  STARVE_LIMIT  4   consecutive LSU grants while IFU waits before IFU is forced; >=1
// PORTS
//  clk              in   1             core clock
//  rst_n            in   1             async active-low reset
//  ifu_req_valid_i  in   1             fetch request
//  ifu_req_ready_o  out  1             fetch request accepted this cycle
//  ifu_addr_i       in   ADDR_WIDTH    fetch address
//  ifu_rsp_valid_o  out  1             fetch data valid (1-cycle pulse)
//  ifu_rsp_data_o   out  DATA_WIDTH    fetch data
//  lsu_req_valid_i  in   1             data request
//  lsu_req_ready_o  out  1             data request accepted this cycle
//  lsu_addr_i       in   ADDR_WIDTH    data address
//  lsu_wen_i        in   1             1=store, 0=load
//  lsu_wdata_i      in   DATA_WIDTH    store data
//  lsu_wmask_i      in   DATA_WIDTH/8  store byte mask
//  lsu_rsp_valid_o  out  1             load data / store ack (1-cycle pulse)
//  lsu_rsp_data_o   out  DATA_WIDTH    load data (don't-care for stores)
//  mem_req_valid_o  out  1             request to memory
//  mem_req_ready_i  in   1             memory accepts request
//  mem_addr_o       out  ADDR_WIDTH    latched address
//  mem_wen_o        out  1             latched write enable
//  mem_wdata_o      out  DATA_WIDTH    latched store data
//  mem_wmask_o      out  DATA_WIDTH/8  latched mask
//  mem_rsp_valid_i  in   1             memory response (loads and store acks)
//  mem_rsp_data_i   in   DATA_WIDTH    memory read data
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, starve_cnt=0, owner=IFU.
//   - All valid/ready outputs 0; mem_addr/wen/wdata/wmask registers 0.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE
//   - IDLE: if any req_valid, pick winner. Winner's *_req_ready_o=1 (combinational, IDLE only).
//     Capture addr/wen/wdata/wmask and owner; next state ISSUE. Loser's ready stays 0.
//     IFU captures always use wen=0, wmask=0.
//   - ISSUE: mem_req_valid_o=1 with stable latched fields until mem_req_ready_i=1; then WAIT.
//   - WAIT: on mem_rsp_valid_i, assert owner's *_rsp_valid_o and pass mem_rsp_data_i
//     combinationally (0-cycle); next state IDLE. Other rsp_valid stays 0.
//  Latency: best case accept@T, mem_req_valid@T+1, rsp@T+2, next accept@T+3.
//  Priority
//   - LSU wins when both valid, unless starve_cnt==STARVE_LIMIT; then IFU wins.
//   - starve_cnt: +1 (saturating at STARVE_LIMIT) on an LSU grant while ifu_req_valid_i=1.
//     Cleared to 0 on any IFU grant. Unchanged otherwise.
//  Boundaries
//   - mem_rsp_valid_i in IDLE/ISSUE is ignored; no rsp_valid is produced.
//   - Response and new request in the same cycle: new request is not accepted until the next
//     cycle (ready only in IDLE).
//   - A requester may drop valid before ready; nothing is captured.
//   - Reset mid-transaction abandons it; a late memory response after reset is ignored.
//   - mem_req_ready_i already 1 on the first ISSUE cycle: handshake completes that cycle.
// STRUCTURE
//  Shared package npc_defs:
//   - ADDR_WIDTH, DATA_WIDTH.
//   - arb_state_e {IDLE, ISSUE, WAIT}.
//   - arb_owner_e {OWN_IFU, OWN_LSU}.
//  Sub-module npc_arb_prio: combinational winner select plus starve_cnt register.
//   - Inputs: both valids, grant strobe.
//   - Outputs: grant_ifu, grant_lsu.
//  Top: FSM, request latch, response demux.
// TESTING
//  1. Reset then IFU-only fetch addr 0x8000_0000, mem ready=1, rsp 0x13 next cycle
//     -> ifu_rsp_valid_o 1 pulse, data 0x13; lsu_rsp_valid_o stays 0.
//  2. IFU and LSU valid same cycle, LSU load 0x8000_1000
//     -> lsu_req_ready_o=1, ifu_req_ready_o=0; LSU served first, IFU accepted in the next IDLE.
//  3. LSU held valid continuously, IFU valid, STARVE_LIMIT=4
//     -> exactly 4 LSU grants, then IFU granted; starve_cnt back to 0.
//  4. Store wdata=0xDEAD_BEEF wmask=0x0F, mem_req_ready_i low 3 cycles
//     -> mem_* stable for those cycles; ack routed to LSU; ifu_rsp_valid_o stays 0.
//  5. rst_n low during WAIT, then late mem_rsp_valid_i
//     -> all outputs 0; no rsp_valid pulse; next request served normally.
//  6. Spurious mem_rsp_valid_i in IDLE -> ignored; state and starve_cnt unchanged.

Source files
------------

// File: rtl/npc_defs.sv
// Shared definitions for the NPC memory arbiter: default widths and the
// state / owner enumerations used by the arbiter and its bench.
package npc_defs;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/npc_arb_prio.sv
// Priority select between fetch (IFU) and load/store (LSU) requests.
// LSU normally wins; once the LSU has been granted STARVE_LIMIT times in a
// row while a fetch was waiting, the fetch is forced through so instruction
// fetch always makes progress.
module npc_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_valid_i,
  input  logic             lsu_valid_i,
  // High on cycles where the winner is actually accepted (arbiter idle).
  input  logic             grant_en_i,
  output logic             grant_ifu_o,
  output logic             grant_lsu_o,
  output logic [CNT_W-1:0] starve_cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  // Winner select: LSU first unless fetch has waited out the starvation limit.
  always_comb begin
    w_starved   = (r_starve_cnt == LIMIT);
    grant_ifu_o = ifu_valid_i && (!lsu_valid_i || w_starved);
    grant_lsu_o = lsu_valid_i && !grant_ifu_o;
  end

  // Starvation counter: counts LSU grants that bypassed a waiting fetch,
  // saturates at the limit, and clears whenever the fetch is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (grant_en_i && grant_ifu_o) begin
      r_starve_cnt <= '0;
    end else if (grant_en_i && grant_lsu_o && ifu_valid_i && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign starve_cnt_o = r_starve_cnt;

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares a single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction is in flight at a time; the request is
// latched on acceptance, presented to memory until accepted, and the memory
// response is steered back to the requester that owns the transaction.
//
// Handshake semantics (all request channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. Ready may depend
// combinationally on valid. A requester may withdraw valid before ready is
// seen; nothing is captured in that case. Response valids are single-cycle
// pulses with no back-pressure.
module npc_mem_arbiter #(
  parameter int ADDR_WIDTH   = npc_defs::ADDR_WIDTH,
  parameter int DATA_WIDTH   = npc_defs::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Instruction fetch side
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data_o,
  // Load/store side
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_wen_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_data_o,
  // Memory side
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data_i,
  // Debug visibility of the FSM and starvation counter
  output logic [1:0]              dbg_state_o,
  output logic [CNT_W-1:0]        dbg_starve_cnt_o
);

  import npc_defs::*;

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  arb_owner_e              r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wen;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wmask;

  logic                    w_idle;
  logic                    w_grant_ifu;
  logic                    w_grant_lsu;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_starve_cnt;

  // Requests are only accepted while idle; that is also when the starvation
  // counter is allowed to move.
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (w_grant_ifu || w_grant_lsu);

  npc_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_valid_i  (ifu_req_valid_i),
    .lsu_valid_i  (lsu_req_valid_i),
    .grant_en_i   (w_idle),
    .grant_ifu_o  (w_grant_ifu),
    .grant_lsu_o  (w_grant_lsu),
    .starve_cnt_o (w_starve_cnt)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: accept -> present to memory -> wait for its response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)        w_state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready_i) w_state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid_i) w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // Outputs: readies only while idle, memory request only while issuing,
  // response steered to the owner only while waiting (stray responses in
  // other states are dropped).
  always_comb begin
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    mem_req_valid_o = 1'b0;
    ifu_rsp_valid_o = 1'b0;
    lsu_rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        ifu_req_ready_o = w_grant_ifu;
        lsu_req_ready_o = w_grant_lsu;
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
      end
      WAIT: begin
        ifu_rsp_valid_o = mem_rsp_valid_i && (r_owner == OWN_IFU);
        lsu_rsp_valid_o = mem_rsp_valid_i && (r_owner == OWN_LSU);
      end
      default: begin
        mem_req_valid_o = 1'b0;
      end
    endcase
  end

  // Request latch: the winner's fields are frozen at acceptance so the memory
  // sees stable values however long it stalls. Fetches are always reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      if (w_grant_lsu) begin
        r_owner <= OWN_LSU;
        r_addr  <= lsu_addr_i;
        r_wen   <= lsu_wen_i;
        r_wdata <= lsu_wdata_i;
        r_wmask <= lsu_wmask_i;
      end else begin
        r_owner <= OWN_IFU;
        r_addr  <= ifu_addr_i;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  assign mem_addr_o       = r_addr;
  assign mem_wen_o        = r_wen;
  assign mem_wdata_o      = r_wdata;
  assign mem_wmask_o      = r_wmask;

  // Read data passes straight through; the valid pulses say who may use it.
  assign ifu_rsp_data_o   = mem_rsp_data_i;
  assign lsu_rsp_data_o   = mem_rsp_data_i;

  assign dbg_state_o      = r_state;
  assign dbg_starve_cnt_o = w_starve_cnt;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Bench for npc_mem_arbiter: directed scenarios driven cycle by cycle, a
// transaction-level reference model checked every cycle, a memory responder,
// and per-requester expected-response queues.
module tb_npc_mem_arbiter;

  import npc_defs::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int MW    = DW / 8;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic          ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
  logic [AW-1:0] ifu_addr_i;
  logic [DW-1:0] ifu_rsp_data_o;
  logic          lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_rsp_valid_o;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i, lsu_rsp_data_o;
  logic [MW-1:0] lsu_wmask_i;
  logic          mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rsp_data_i;
  logic [MW-1:0] mem_wmask_o;
  logic [1:0]    dbg_state_o;
  logic [2:0]    dbg_starve_cnt_o;

  npc_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_valid_i  (ifu_req_valid_i),
    .ifu_req_ready_o  (ifu_req_ready_o),
    .ifu_addr_i       (ifu_addr_i),
    .ifu_rsp_valid_o  (ifu_rsp_valid_o),
    .ifu_rsp_data_o   (ifu_rsp_data_o),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wen_i        (lsu_wen_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_wmask_i      (lsu_wmask_i),
    .lsu_rsp_valid_o  (lsu_rsp_valid_o),
    .lsu_rsp_data_o   (lsu_rsp_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_wmask_o      (mem_wmask_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .dbg_state_o      (dbg_state_o),
    .dbg_starve_cnt_o (dbg_starve_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int            checks;
  int            errors;
  logic [DW-1:0] exp_ifu_q[$];
  logic [DW-1:0] exp_lsu_q[$];
  logic [DW-1:0] mem_data_q[$];
  int            grant_log[$];   // 0 = IFU accepted, 1 = LSU accepted
  int            ifu_pulses;
  int            lsu_pulses;
  int            issue_cycles;

  // Transaction-level reference: is a transaction held, has memory taken it,
  // who owns it, what was captured, and how many fetch bypasses so far.
  bit            m_busy;
  bit            m_sent;
  bit            m_own_lsu;
  logic [AW-1:0] m_addr;
  bit            m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  int            m_starve;

  // Memory responder knobs
  int mem_stall;
  int rsp_delay;
  int spur_req;
  int spur_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  task automatic compare_loop();
    bit ifu_win, lsu_win, exp_mrv, exp_irv, exp_lrv;
    int exp_state;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        chk("rst_ifu_ready", ifu_req_ready_o, 0);
        chk("rst_lsu_ready", lsu_req_ready_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_ifu_rsp", ifu_rsp_valid_o, 0);
        chk("rst_lsu_rsp", lsu_rsp_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wen", mem_wen_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_wmask", mem_wmask_o, 0);
        chk("rst_state", dbg_state_o, 0);
        chk("rst_starve", dbg_starve_cnt_o, 0);
        m_busy = 0; m_sent = 0; m_own_lsu = 0; m_starve = 0;
      end else begin
        ifu_win   = !m_busy && ifu_req_valid_i && (!lsu_req_valid_i || m_starve == LIMIT);
        lsu_win   = !m_busy && lsu_req_valid_i && !ifu_win;
        exp_mrv   = m_busy && !m_sent;
        exp_irv   = m_busy && m_sent && !m_own_lsu && mem_rsp_valid_i;
        exp_lrv   = m_busy && m_sent && m_own_lsu && mem_rsp_valid_i;
        exp_state = !m_busy ? 0 : (!m_sent ? 1 : 2);
        chk("ifu_ready", ifu_req_ready_o, ifu_win);
        chk("lsu_ready", lsu_req_ready_o, lsu_win);
        chk("mem_req_valid", mem_req_valid_o, exp_mrv);
        chk("ifu_rsp_valid", ifu_rsp_valid_o, exp_irv);
        chk("lsu_rsp_valid", lsu_rsp_valid_o, exp_lrv);
        chk("state", dbg_state_o, exp_state);
        chk("starve_cnt", dbg_starve_cnt_o, m_starve);
        if (exp_mrv) begin
          chk("mem_addr", mem_addr_o, m_addr);
          chk("mem_wen", mem_wen_o, m_wen);
          chk("mem_wmask", mem_wmask_o, m_wmask);
          if (m_wen) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        if (exp_irv) chk("ifu_rsp_data", ifu_rsp_data_o, mem_rsp_data_i);
        if (exp_lrv) chk("lsu_rsp_data", lsu_rsp_data_o, mem_rsp_data_i);
        // observation log and expected-response scoreboard
        if (ifu_req_ready_o) grant_log.push_back(0);
        if (lsu_req_ready_o) grant_log.push_back(1);
        if (mem_req_valid_o) issue_cycles++;
        if (ifu_rsp_valid_o) begin
          ifu_pulses++;
          if (exp_ifu_q.size() == 0) chk("ifu_rsp_unexpected", 1, 0);
          else chk("ifu_rsp_sb", ifu_rsp_data_o, exp_ifu_q.pop_front());
        end
        if (lsu_rsp_valid_o) begin
          lsu_pulses++;
          if (exp_lsu_q.size() == 0) chk("lsu_rsp_unexpected", 1, 0);
          else chk("lsu_rsp_sb", lsu_rsp_data_o, exp_lsu_q.pop_front());
        end
        // advance the model across the coming clock edge
        if (ifu_win) begin
          m_busy = 1; m_sent = 0; m_own_lsu = 0; m_addr = ifu_addr_i;
          m_wen = 0; m_wdata = '0; m_wmask = '0; m_starve = 0;
        end else if (lsu_win) begin
          m_busy = 1; m_sent = 0; m_own_lsu = 1; m_addr = lsu_addr_i;
          m_wen = lsu_wen_i; m_wdata = lsu_wdata_i; m_wmask = lsu_wmask_i;
          if (ifu_req_valid_i && m_starve < LIMIT) m_starve++;
        end else if (m_busy && !m_sent && mem_req_ready_i) begin
          m_sent = 1;
        end else if (m_busy && m_sent && mem_rsp_valid_i) begin
          m_busy = 0;
        end
      end
    end
  endtask

  // ---------------- memory responder ----------------
  task automatic responder();
    bit pend;
    int hold;
    int stall_left;
    pend = 0; hold = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      #1;
      mem_rsp_valid_i = 1'b0;
      if (!rst_n) begin
        mem_req_ready_i = 1'b0;
        pend = 0;
        stall_left = mem_stall;
      end else begin
        if (pend) begin
          if (hold > 0) hold--;
          else begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            pend = 0;
          end
        end else if (spur_req != spur_done) begin
          spur_done++;
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = 64'h5EE5_5EE5_5EE5_5EE5;
        end
        if (mem_req_valid_o) begin
          if (stall_left > 0) begin
            mem_req_ready_i = 1'b0;
            stall_left--;
          end else begin
            mem_req_ready_i = 1'b1;
            pend = 1;
            hold = rsp_delay;
          end
        end else begin
          mem_req_ready_i = 1'b0;
          stall_left = mem_stall;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ifu_fetch(input logic [AW-1:0] a);
    bit got = 0;
    @(negedge clk);
    ifu_req_valid_i = 1'b1;
    ifu_addr_i      = a;
    for (int k = 0; k < 100; k++) begin
      #4;
      if (ifu_req_ready_o) begin got = 1; break; end
      @(negedge clk);
    end
    chk("ifu_accept_timeout", got, 1);
    @(negedge clk);
    ifu_req_valid_i = 1'b0;
  endtask

  task automatic lsu_req(input logic [AW-1:0] a, input bit wen,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    bit got = 0;
    @(negedge clk);
    lsu_req_valid_i = 1'b1;
    lsu_addr_i = a; lsu_wen_i = wen; lsu_wdata_i = wd; lsu_wmask_i = wm;
    for (int k = 0; k < 100; k++) begin
      #4;
      if (lsu_req_ready_o) begin got = 1; break; end
      @(negedge clk);
    end
    chk("lsu_accept_timeout", got, 1);
    @(negedge clk);
    lsu_req_valid_i = 1'b0;
  endtask

  // LSU keeps valid asserted back to back for n loads.
  task automatic lsu_stream(input int n, input logic [AW-1:0] base);
    bit got;
    @(negedge clk);
    lsu_req_valid_i = 1'b1;
    lsu_wen_i = 1'b0; lsu_wdata_i = '0; lsu_wmask_i = '0;
    for (int i = 0; i < n; i++) begin
      lsu_addr_i = base + AW'(i * 8);
      got = 0;
      for (int k = 0; k < 100; k++) begin
        #4;
        if (lsu_req_ready_o) begin got = 1; break; end
        @(negedge clk);
      end
      chk("lsu_stream_timeout", got, 1);
      @(negedge clk);
    end
    lsu_req_valid_i = 1'b0;
  endtask

  task automatic wait_pulses(input int ni, input int nl, input string name);
    bit done = 0;
    for (int k = 0; k < 200; k++) begin
      if (ifu_pulses >= ni && lsu_pulses >= nl) begin done = 1; break; end
      @(negedge clk);
      #6;
    end
    chk(name, done, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int p_ifu, p_lsu;
    checks = 0; errors = 0; ifu_pulses = 0; lsu_pulses = 0; issue_cycles = 0;
    mem_stall = 0; rsp_delay = 0; spur_req = 0; spur_done = 0;
    m_busy = 0; m_sent = 0; m_own_lsu = 0; m_starve = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
    rst_n = 1'b0;
    ifu_req_valid_i = 0; ifu_addr_i = '0;
    lsu_req_valid_i = 0; lsu_addr_i = '0; lsu_wen_i = 0; lsu_wdata_i = '0; lsu_wmask_i = '0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
    fork
      compare_loop();
      responder();
    join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: lone fetch, data 0x13
    mem_data_q.push_back(64'h13); exp_ifu_q.push_back(64'h13);
    ifu_fetch(32'h8000_0000);
    wait_pulses(1, 0, "t1_rsp_timeout");
    chk("t1_ifu_pulses", ifu_pulses, 1);
    chk("t1_lsu_pulses", lsu_pulses, 0);
    chk("t1_issue_cycles", issue_cycles, 1);

    // 2: simultaneous requests, LSU first then IFU
    grant_log.delete();
    mem_data_q.push_back(64'h1111); exp_lsu_q.push_back(64'h1111);
    mem_data_q.push_back(64'h2222); exp_ifu_q.push_back(64'h2222);
    fork
      ifu_fetch(32'h8000_0004);
      lsu_req(32'h8000_1000, 1'b0, '0, '0);
    join
    wait_pulses(2, 1, "t2_rsp_timeout");
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first_lsu", grant_log[0], 1);
      chk("t2_second_ifu", grant_log[1], 0);
    end

    // 3: LSU back to back against a waiting fetch
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      mem_data_q.push_back(64'hA0 + 64'(i)); exp_lsu_q.push_back(64'hA0 + 64'(i));
    end
    mem_data_q.push_back(64'hF3); exp_ifu_q.push_back(64'hF3);
    mem_data_q.push_back(64'hA4); exp_lsu_q.push_back(64'hA4);
    fork
      ifu_fetch(32'h8000_0100);
      lsu_stream(5, 32'h8000_2000);
    join
    wait_pulses(3, 6, "t3_rsp_timeout");
    chk("t3_grants", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      for (int i = 0; i < 4; i++) chk("t3_lsu_grant", grant_log[i], 1);
      chk("t3_ifu_forced", grant_log[4], 0);
      chk("t3_lsu_after", grant_log[5], 1);
    end
    chk("t3_starve_clear", dbg_starve_cnt_o, 0);

    // 4: store with memory stalling three cycles
    p_ifu = ifu_pulses; issue_cycles = 0;
    mem_stall = 3;
    mem_data_q.push_back(64'h0); exp_lsu_q.push_back(64'h0);
    lsu_req(32'h8000_3000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    wait_pulses(p_ifu, 7, "t4_rsp_timeout");
    mem_stall = 0;
    chk("t4_issue_cycles", issue_cycles, 4);
    chk("t4_no_ifu_rsp", ifu_pulses, p_ifu);
    chk("t4_lsu_pulses", lsu_pulses, 7);

    // 5: reset while waiting for a response, then a late response
    p_ifu = ifu_pulses; p_lsu = lsu_pulses;
    rsp_delay = 3;
    ifu_fetch(32'h8000_0200);
    repeat (2) @(negedge clk);
    #4;
    chk("t5_in_wait", dbg_state_o, 2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_delay = 0;
    spur_req++;
    repeat (4) @(negedge clk);
    #6;
    chk("t5_no_ifu_rsp", ifu_pulses, p_ifu);
    chk("t5_no_lsu_rsp", lsu_pulses, p_lsu);
    chk("t5_idle", dbg_state_o, 0);
    mem_data_q.push_back(64'h77); exp_lsu_q.push_back(64'h77);
    lsu_req(32'h8000_4000, 1'b0, '0, '0);
    wait_pulses(p_ifu, p_lsu + 1, "t5_rsp_timeout");

    // 6: fetch withdrawn before ready, then spurious response in idle
    p_ifu = ifu_pulses; p_lsu = lsu_pulses;
    mem_data_q.push_back(64'h66); exp_lsu_q.push_back(64'h66);
    fork
      begin
        @(negedge clk);
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_0300;
      end
      lsu_req(32'h8000_5000, 1'b0, '0, '0);
    join
    ifu_req_valid_i = 1'b0;
    wait_pulses(p_ifu, p_lsu + 1, "t6_rsp_timeout");
    chk("t6_starve_one", dbg_starve_cnt_o, 1);
    spur_req++;
    repeat (3) @(negedge clk);
    #6;
    chk("t6_starve_kept", dbg_starve_cnt_o, 1);
    chk("t6_idle", dbg_state_o, 0);
    chk("t6_no_ifu_rsp", ifu_pulses, p_ifu);
    chk("t6_no_lsu_rsp", lsu_pulses, p_lsu + 1);

    chk("exp_ifu_q_empty", exp_ifu_q.size(), 0);
    chk("exp_lsu_q_empty", exp_lsu_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
